operand_fetch: RTL and testbench

Register-read stage of the RV32I pipeline, between decode and execute. Takes one decoded instruction per cycle over a valid/ready handshake and issues the synchronous read to the `regFile` block. It captures the read data one cycle later and forwards writeback results that the synchronous read misses. It holds operands in an output register that keeps tracking writebacks while execute stalls.

---
 rtl/operand_fetch_if.sv | 59 +++++
 rtl/operand_fetch.sv | 155 +++++++++++++++
 tb/tb_operand_fetch.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/operand_fetch_if.sv
// operand_fetch_if
//   Bundles every non-clock signal of the operand_fetch stage.
//   in_*  : decode -> stage instruction handshake (valid/ready) and fields
//   rf_*  : stage <-> register file synchronous read port
//   wb_*  : writeback broadcast (same strobe as the register file write)
//   out_* : stage -> execute operand handshake (valid/ready) and fields
//   slave  : view taken by the operand_fetch stage itself
//   master : view taken by the surrounding pipeline / environment
interface operand_fetch_if #(
    parameter int XLEN   = 32,
    parameter int AW     = 5,
    parameter int META_W = 64
);
    logic              in_valid;
    logic              in_ready;
    logic [AW-1:0]     in_rs1;
    logic [AW-1:0]     in_rs2;
    logic              in_use_rs1;
    logic              in_use_rs2;
    logic [AW-1:0]     in_rd;
    logic [META_W-1:0] in_meta;

    logic [AW-1:0]     rf_rs1;
    logic [AW-1:0]     rf_rs2;
    logic              rf_rv;
    logic [XLEN-1:0]   rf_rd1;
    logic [XLEN-1:0]   rf_rd2;

    logic              wb_valid;
    logic [AW-1:0]     wb_rd;
    logic [XLEN-1:0]   wb_data;

    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_rs1_val;
    logic [XLEN-1:0]   out_rs2_val;
    logic [AW-1:0]     out_rd;
    logic [META_W-1:0] out_meta;

    modport slave (
        input  in_valid, in_rs1, in_rs2, in_use_rs1, in_use_rs2, in_rd, in_meta,
        output in_ready,
        output rf_rs1, rf_rs2, rf_rv,
        input  rf_rd1, rf_rd2,
        input  wb_valid, wb_rd, wb_data,
        output out_valid, out_rs1_val, out_rs2_val, out_rd, out_meta,
        input  out_ready
    );

    modport master (
        output in_valid, in_rs1, in_rs2, in_use_rs1, in_use_rs2, in_rd, in_meta,
        input  in_ready,
        input  rf_rs1, rf_rs2, rf_rv,
        output rf_rd1, rf_rd2,
        output wb_valid, wb_rd, wb_data,
        input  out_valid, out_rs1_val, out_rs2_val, out_rd, out_meta,
        output out_ready
    );
endinterface

// File: rtl/operand_fetch.sv
// operand_fetch
//   RV32I register-read stage between decode and execute. Issues the
//   synchronous register file read on accept, resolves operands one cycle
//   later with writeback forwarding, and holds them in an output register
//   that keeps snooping writebacks while execute stalls.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : operand_fetch_if.slave (decode handshake, register file read
//           port, writeback broadcast, execute handshake)
module operand_fetch #(
    parameter int XLEN   = 32,
    parameter int AW     = 5,
    parameter int META_W = 64
) (
    input  logic           clk,
    input  logic           reset,
    operand_fetch_if.slave bus
);

    // S1: read in flight
    logic              s1_valid;
    logic [AW-1:0]     s1_rs1, s1_rs2;
    logic              s1_use1, s1_use2;
    logic [AW-1:0]     s1_rd;
    logic [META_W-1:0] s1_meta;
    logic              s1_hit1, s1_hit2;
    logic [XLEN-1:0]   s1_byp1, s1_byp2;

    // OUT: operands presented to execute
    logic              out_valid;
    logic [XLEN-1:0]   out_rs1_val, out_rs2_val;
    logic [AW-1:0]     out_rs1, out_rs2;
    logic              out_use1, out_use2;
    logic [AW-1:0]     out_rd;
    logic [META_W-1:0] out_meta;

    logic              out_adv;
    logic              in_ready;
    logic              accept;
    logic              s1_adv;
    logic              acc_hit1, acc_hit2;
    logic [XLEN-1:0]   s1_op1, s1_op2;

    assign out_adv  = !out_valid || bus.out_ready;
    assign in_ready = !s1_valid || out_adv;
    assign accept   = bus.in_valid && in_ready;
    assign s1_adv   = s1_valid && out_adv;

    // The register file returns the old value on a same-cycle read/write,
    // so a writeback seen in the accept cycle is captured here.
    assign acc_hit1 = bus.wb_valid && (bus.wb_rd == bus.in_rs1) && (bus.in_rs1 != '0);
    assign acc_hit2 = bus.wb_valid && (bus.wb_rd == bus.in_rs2) && (bus.in_rs2 != '0);

    // Resolved S1 operands. Once S1 has been held for a cycle the hit flag is
    // forced on, so rf_rd* is only ever used in the cycle right after the read.
    always_comb begin
        s1_op1 = bus.rf_rd1;
        if (!s1_use1 || s1_rs1 == '0)
            s1_op1 = '0;
        else if (bus.wb_valid && bus.wb_rd == s1_rs1)
            s1_op1 = bus.wb_data;
        else if (s1_hit1)
            s1_op1 = s1_byp1;
    end

    always_comb begin
        s1_op2 = bus.rf_rd2;
        if (!s1_use2 || s1_rs2 == '0)
            s1_op2 = '0;
        else if (bus.wb_valid && bus.wb_rd == s1_rs2)
            s1_op2 = bus.wb_data;
        else if (s1_hit2)
            s1_op2 = s1_byp2;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_rs1   <= '0;
            s1_rs2   <= '0;
            s1_use1  <= 1'b0;
            s1_use2  <= 1'b0;
            s1_rd    <= '0;
            s1_meta  <= '0;
            s1_hit1  <= 1'b0;
            s1_hit2  <= 1'b0;
            s1_byp1  <= '0;
            s1_byp2  <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_rs1   <= bus.in_rs1;
            s1_rs2   <= bus.in_rs2;
            s1_use1  <= bus.in_use_rs1;
            s1_use2  <= bus.in_use_rs2;
            s1_rd    <= bus.in_rd;
            s1_meta  <= bus.in_meta;
            s1_hit1  <= acc_hit1;
            s1_hit2  <= acc_hit2;
            s1_byp1  <= bus.wb_data;
            s1_byp2  <= bus.wb_data;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end else if (s1_valid) begin
            // Held behind a stalled OUT: latch the resolved value so the read
            // data is kept and later writebacks keep being folded in.
            s1_hit1  <= 1'b1;
            s1_hit2  <= 1'b1;
            s1_byp1  <= s1_op1;
            s1_byp2  <= s1_op2;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid   <= 1'b0;
            out_rs1_val <= '0;
            out_rs2_val <= '0;
            out_rs1     <= '0;
            out_rs2     <= '0;
            out_use1    <= 1'b0;
            out_use2    <= 1'b0;
            out_rd      <= '0;
            out_meta    <= '0;
        end else if (s1_adv) begin
            out_valid   <= 1'b1;
            out_rs1_val <= s1_op1;
            out_rs2_val <= s1_op2;
            out_rs1     <= s1_rs1;
            out_rs2     <= s1_rs2;
            out_use1    <= s1_use1;
            out_use2    <= s1_use2;
            out_rd      <= s1_rd;
            out_meta    <= s1_meta;
        end else if (out_valid && !bus.out_ready) begin
            if (bus.wb_valid && bus.wb_rd == out_rs1 && out_rs1 != '0 && out_use1)
                out_rs1_val <= bus.wb_data;
            if (bus.wb_valid && bus.wb_rd == out_rs2 && out_rs2 != '0 && out_use2)
                out_rs2_val <= bus.wb_data;
        end else if (bus.out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.rf_rs1      = bus.in_rs1;
    assign bus.rf_rs2      = bus.in_rs2;
    assign bus.rf_rv       = accept;
    assign bus.out_valid   = out_valid;
    assign bus.out_rs1_val = out_rs1_val;
    assign bus.out_rs2_val = out_rs2_val;
    assign bus.out_rd      = out_rd;
    assign bus.out_meta    = out_meta;

endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    operand_fetch_if #(.XLEN(32), .AW(5), .META_W(64)) bus ();

    operand_fetch #(.XLEN(32), .AW(5), .META_W(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        u1;
        logic        u2;
        logic [4:0]  rd;
        logic [63:0] meta;
    } item_t;

    item_t sb[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    bit    rnd     = 1'b0;

    // Register file model: synchronous read returning pre-write data, x0 fixed.
    logic [31:0] mem [32];
    always @(posedge clk) begin
        if (bus.rf_rv) begin
            bus.rf_rd1 <= mem[bus.rf_rs1];
            bus.rf_rd2 <= mem[bus.rf_rs2];
        end
        if (bus.wb_valid && bus.wb_rd != 5'd0)
            mem[bus.wb_rd] <= bus.wb_data;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Output scoreboard: operands must equal the architectural register value
    // including every writeback before the consuming cycle.
    always @(negedge clk) begin
        item_t       it;
        logic [31:0] e1, e2;
        if (reset && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 64'd1, 64'd0);
            end else begin
                it = sb.pop_front();
                e1 = (it.u1 && it.rs1 != 5'd0) ? mem[it.rs1] : 32'd0;
                e2 = (it.u2 && it.rs2 != 5'd0) ? mem[it.rs2] : 32'd0;
                check("sb_meta", bus.out_meta, it.meta);
                check("sb_rd", 64'(bus.out_rd), 64'(it.rd));
                check("sb_rs1_val", 64'(bus.out_rs1_val), 64'(e1));
                check("sb_rs2_val", 64'(bus.out_rs2_val), 64'(e2));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rnd) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.wb_valid  = 1'($urandom_range(0, 1));
            bus.wb_rd     = 5'($urandom_range(0, 7));
            bus.wb_data   = $urandom;
        end
    endtask

    task automatic send(input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2,
                        input logic [4:0] rd, input logic [63:0] meta);
        item_t it;
        int    n = 0;
        bus.in_valid   = 1'b1;
        bus.in_rs1     = rs1;
        bus.in_rs2     = rs2;
        bus.in_use_rs1 = u1;
        bus.in_use_rs2 = u2;
        bus.in_rd      = rd;
        bus.in_meta    = meta;
        it.rs1 = rs1; it.rs2 = rs2; it.u1 = u1; it.u2 = u2; it.rd = rd; it.meta = meta;
        forever begin
            #1;
            if (bus.in_ready) begin
                sb.push_back(it);
                step();
                return;
            end
            step();
            n++;
            if (n > 100) begin
                check("send_timeout", 64'd0, 64'd1);
                return;
            end
        end
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = a;
        bus.wb_data  = d;
        step();
        bus.wb_valid = 1'b0;
    endtask

    initial begin
        logic [5:0] vec;
        reset          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_rs1     = '0;
        bus.in_rs2     = '0;
        bus.in_use_rs1 = 1'b0;
        bus.in_use_rs2 = 1'b0;
        bus.in_rd      = '0;
        bus.in_meta    = '0;
        bus.wb_valid   = 1'b0;
        bus.wb_rd      = '0;
        bus.wb_data    = '0;
        bus.out_ready  = 1'b1;

        #2;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_rs1", 64'(bus.out_rs1_val), 64'd0);
        check("rst_out_rs2", 64'(bus.out_rs2_val), 64'd0);
        check("rst_out_rd", 64'(bus.out_rd), 64'd0);
        check("rst_out_meta", bus.out_meta, 64'd0);
        #20 reset = 1'b1;
        #1;
        check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("post_rst_rf_rv", 64'(bus.rf_rv), 64'd0);
        step();

        for (int r = 1; r < 8; r++) wb_write(5'(r), 32'(r * 32'h101));
        wb_write(5'd5, 32'h11);
        wb_write(5'd6, 32'h22);
        wb_write(5'd7, 32'h77);

        // Basic read and latency
        send(5'd5, 5'd6, 1'b1, 1'b1, 5'd1, 64'hA1);
        bus.in_valid = 1'b0;
        check("lat_not_yet", 64'(bus.out_valid), 64'd0);
        step();
        check("basic_out_valid", 64'(bus.out_valid), 64'd1);
        check("basic_rs1", 64'(bus.out_rs1_val), 64'h11);
        check("basic_rs2", 64'(bus.out_rs2_val), 64'h22);
        step();

        // Four back-to-back
        send(5'd1, 5'd2, 1'b1, 1'b1, 5'd2, 64'hB1); vec[5] = bus.out_valid;
        send(5'd3, 5'd4, 1'b1, 1'b1, 5'd3, 64'hB2); vec[4] = bus.out_valid;
        send(5'd5, 5'd6, 1'b1, 1'b1, 5'd4, 64'hB3); vec[3] = bus.out_valid;
        send(5'd7, 5'd1, 1'b1, 1'b1, 5'd5, 64'hB4); vec[2] = bus.out_valid;
        bus.in_valid = 1'b0;
        step(); vec[1] = bus.out_valid;
        step(); vec[0] = bus.out_valid;
        check("b2b_valid_pattern", 64'(vec), 64'(6'b011110));

        // x0 and unused operand
        bus.wb_valid = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'hDEAD;
        send(5'd0, 5'd7, 1'b1, 1'b0, 5'd3, 64'hC1);
        bus.in_valid = 1'b0;
        step();
        bus.wb_valid = 1'b0;
        check("x0_out_valid", 64'(bus.out_valid), 64'd1);
        check("x0_rs1", 64'(bus.out_rs1_val), 64'd0);
        check("unused_rs2", 64'(bus.out_rs2_val), 64'd0);
        step();

        // Accept-cycle bypass
        bus.wb_valid = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'hAAAA;
        send(5'd5, 5'd6, 1'b1, 1'b1, 5'd4, 64'hD1);
        bus.wb_valid = 1'b0;
        bus.in_valid = 1'b0;
        step();
        check("byp_accept_rs1", 64'(bus.out_rs1_val), 64'hAAAA);
        step();

        // S1-cycle bypass
        send(5'd5, 5'd6, 1'b1, 1'b1, 5'd5, 64'hD2);
        bus.in_valid = 1'b0;
        bus.wb_valid = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'hBBBB;
        step();
        bus.wb_valid = 1'b0;
        check("byp_s1_rs1", 64'(bus.out_rs1_val), 64'hBBBB);
        step();

        // Stall with both slots full, snoop in stall cycle 2
        bus.out_ready = 1'b0;
        send(5'd5, 5'd6, 1'b1, 1'b1, 5'd6, 64'hE1);
        send(5'd6, 5'd6, 1'b1, 1'b1, 5'd7, 64'hE2);
        bus.in_valid = 1'b1; bus.in_rs1 = 5'd5; bus.in_rs2 = 5'd6; bus.in_meta = 64'hE3;
        for (int c = 1; c <= 4; c++) begin
            #1;
            check("stall_in_ready", 64'(bus.in_ready), 64'd0);
            check("stall_rf_rv", 64'(bus.rf_rv), 64'd0);
            if (c == 2) begin
                bus.wb_valid = 1'b1; bus.wb_rd = 5'd6; bus.wb_data = 32'h1234;
            end
            step();
            bus.wb_valid = 1'b0;
        end
        bus.out_ready = 1'b1;
        check("stall_release_meta", bus.out_meta, 64'hE1);
        check("stall_snoop_rs2", 64'(bus.out_rs2_val), 64'h1234);
        send(5'd5, 5'd6, 1'b1, 1'b1, 5'd8, 64'hE3);
        bus.in_valid = 1'b0;
        check("stall_next_valid", 64'(bus.out_valid), 64'd1);
        check("stall_next_meta", bus.out_meta, 64'hE2);
        check("stall_s1_rs1", 64'(bus.out_rs1_val), 64'h1234);
        check("stall_s1_rs2", 64'(bus.out_rs2_val), 64'h1234);
        step(); step(); step();

        // Reset mid-operation with both slots full
        bus.out_ready = 1'b0;
        send(5'd1, 5'd2, 1'b1, 1'b1, 5'd9, 64'hF1);
        send(5'd3, 5'd4, 1'b1, 1'b1, 5'd10, 64'hF2);
        bus.in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_rs1", 64'(bus.out_rs1_val), 64'd0);
        check("mid_rst_rs2", 64'(bus.out_rs2_val), 64'd0);
        check("mid_rst_rd", 64'(bus.out_rd), 64'd0);
        check("mid_rst_meta", bus.out_meta, 64'd0);
        sb.delete();
        #10 reset = 1'b1;
        #1;
        check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b1;
        step();
        check("mid_rst_no_output", 64'(bus.out_valid), 64'd0);

        // Randomised traffic with stalls and writebacks
        rnd = 1'b1;
        for (int i = 0; i < 60; i++)
            send(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 5'(i), 64'h100 + 64'(i));
        rnd = 1'b0;
        bus.in_valid  = 1'b0;
        bus.wb_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) step();
        check("drain_sb_empty", 64'(sb.size()), 64'd0);
        check("drain_out_valid", 64'(bus.out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
